// File: rtl/rv32i_types.sv
// Shared RV32IM types used by the out-of-order backend: reservation station
// entry payload, common data bus record and M-extension funct3 encodings.
package rv32i_types;

  // M-extension funct3 encodings (multiply and divide share one opcode)
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mult_div_op_t;

  // One renamed operation waiting in a reservation station
  typedef struct packed {
    logic [4:0] rob_id;
    logic [4:0] rd_addr;
    logic [5:0] pd_addr;
    logic [5:0] ps1_addr;
    logic [5:0] ps2_addr;
    logic [2:0] funct3;
  } rs_entry_t;

  // Common data bus broadcast; pr_dest 0 is the hard-wired zero register
  typedef struct packed {
    logic        ready;
    logic [4:0]  rob_id;
    logic [4:0]  rd_addr;
    logic [5:0]  pr_dest;
    logic [31:0] data;
  } cdb_t;

endpackage

// File: rtl/mul_res_station_age_matrix.sv
// Oldest-first picker for a reservation station. olderQ[i][j] = 1 means
// entry i was dispatched before entry j. A newly allocated entry becomes
// younger than everything; rows/columns of freed entries are cleared.
module rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] eligible_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // Next matrix: clear relations of freed entries, then make the new entry youngest
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (free_i[i] || free_i[j]) older_d[i][j] = 1'b0;
        if (alloc_i[j] && (i != j)) older_d[i][j] = 1'b1;
        if (alloc_i[i]) older_d[i][j] = 1'b0;
      end
    end
  end

  // Matrix register; reset leaves no ordering relations
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // Grant the eligible entry that no other eligible entry is older than
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = eligible_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && eligible_i[j] && older_q[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_res_station.sv
// Multiply-unit reservation station: holds renamed multiply ops until both
// sources are ready, snoops the CDB for wakeup and issues oldest-first.
module mul_res_station
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      dispatch_valid,
  input  rs_entry_t dispatch_entry,
  input  logic      dispatch_ps1_ready,
  input  logic      dispatch_ps2_ready,
  output logic      full,
  input  cdb_t      cdb,
  output logic      rs_entry_valid,
  output rs_entry_t rs_entry_dout,
  input  logic      fu_ready
);

  logic [DEPTH-1:0] entryValid_q, entryValid_d;
  logic [DEPTH-1:0] ps1Rdy_q, ps1Rdy_d;
  logic [DEPTH-1:0] ps2Rdy_q, ps2Rdy_d;
  rs_entry_t        payload_q [DEPTH];

  logic [DEPTH-1:0] freeSel;
  logic [DEPTH-1:0] allocSel;
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] issueSel;
  logic             dispatchFire;
  logic             issueFire;
  logic             dispRdy1;
  logic             dispRdy2;
  logic             unusedCdb;

  // Only ready and pr_dest matter for wakeup
  assign unusedCdb = ^{cdb.rob_id, cdb.rd_addr, cdb.data};

  assign full         = &entryValid_q;
  assign dispatchFire = dispatch_valid & ~full & ~flush;
  assign eligible     = entryValid_q & ps1Rdy_q & ps2Rdy_q;
  assign rs_entry_valid = (|eligible) & ~flush;
  assign issueFire    = rs_entry_valid & fu_ready;
  assign issueSel     = grant & {DEPTH{issueFire}};
  assign allocSel     = freeSel & {DEPTH{dispatchFire}};

  // Source readiness at dispatch, including a same-cycle CDB bypass
  always_comb begin
    dispRdy1 = dispatch_ps1_ready || (dispatch_entry.ps1_addr == 6'd0) ||
               (cdb.ready && (cdb.pr_dest == dispatch_entry.ps1_addr));
    dispRdy2 = dispatch_ps2_ready || (dispatch_entry.ps2_addr == 6'd0) ||
               (cdb.ready && (cdb.pr_dest == dispatch_entry.ps2_addr));
  end

  // Lowest-index free slot; an issuing entry is still valid so never chosen
  always_comb begin
    logic found;
    freeSel = '0;
    found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entryValid_q[i] && !found) begin
        freeSel[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) ageMatrix (
    .clk        (clk),
    .rst        (rst),
    .alloc_i    (allocSel),
    .free_i     (issueSel),
    .eligible_i (eligible),
    .grant_o    (grant)
  );

  // Present the granted payload; one-hot grant so a priority mux is exact
  always_comb begin
    rs_entry_dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) rs_entry_dout = payload_q[i];
    end
  end

  // Next valid/ready state: issue frees, CDB wakes, dispatch fills; flush empties
  always_comb begin
    entryValid_d = entryValid_q;
    ps1Rdy_d     = ps1Rdy_q;
    ps2Rdy_d     = ps2Rdy_q;
    if (flush) begin
      entryValid_d = '0;
      ps1Rdy_d     = '0;
      ps2Rdy_d     = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issueSel[i]) entryValid_d[i] = 1'b0;
        if (entryValid_q[i] && cdb.ready && (cdb.pr_dest != 6'd0)) begin
          if (cdb.pr_dest == payload_q[i].ps1_addr) ps1Rdy_d[i] = 1'b1;
          if (cdb.pr_dest == payload_q[i].ps2_addr) ps2Rdy_d[i] = 1'b1;
        end
        if (allocSel[i]) begin
          entryValid_d[i] = 1'b1;
          ps1Rdy_d[i]     = dispRdy1;
          ps2Rdy_d[i]     = dispRdy2;
        end
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      entryValid_q <= '0;
      ps1Rdy_q     <= '0;
      ps2Rdy_q     <= '0;
    end else begin
      entryValid_q <= entryValid_d;
      ps1Rdy_q     <= ps1Rdy_d;
      ps2Rdy_q     <= ps2Rdy_d;
    end
  end

  // Payload storage, written only on allocation and never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (allocSel[i]) payload_q[i] <= dispatch_entry;
    end
  end

endmodule

// File: tb/tb_mul_res_station.sv
// Directed bench for mul_res_station: a vector table walks through the main
// scenarios cycle by cycle, then short hand-written sequences cover wakeup
// latency, reset mid-operation and flush overriding wakeup.
module tb_mul_res_station;
  import rv32i_types::*;

  logic      clk;
  logic      rst;
  logic      flush;
  logic      dispatch_valid;
  rs_entry_t dispatch_entry;
  logic      dispatch_ps1_ready;
  logic      dispatch_ps2_ready;
  logic      full;
  cdb_t      cdb;
  logic      rs_entry_valid;
  rs_entry_t rs_entry_dout;
  logic      fu_ready;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic       dv;
    logic [4:0] rob;
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic       r1;
    logic       r2;
    logic       cr;
    logic [5:0] cd;
    logic       fu;
    logic       fl;
    logic       rs;
    logic       ev;
    logic       ef;
    logic [4:0] erob;
  } vec_t;

  vec_t vecs[$];

  mul_res_station #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_entry     (dispatch_entry),
    .dispatch_ps1_ready (dispatch_ps1_ready),
    .dispatch_ps2_ready (dispatch_ps2_ready),
    .full               (full),
    .cdb                (cdb),
    .rs_entry_valid     (rs_entry_valid),
    .rs_entry_dout      (rs_entry_dout),
    .fu_ready           (fu_ready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input int dv, input int rob, input int ps1, input int ps2,
                                 input int r1, input int r2, input int cr, input int cd,
                                 input int fu, input int fl, input int rs,
                                 input int ev, input int ef, input int erob);
    vec_t v;
    v.dv = 1'(dv); v.rob = 5'(rob); v.ps1 = 6'(ps1); v.ps2 = 6'(ps2);
    v.r1 = 1'(r1); v.r2 = 1'(r2); v.cr = 1'(cr); v.cd = 6'(cd);
    v.fu = 1'(fu); v.fl = 1'(fl); v.rs = 1'(rs);
    v.ev = 1'(ev); v.ef = 1'(ef); v.erob = 5'(erob);
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int fu, input int ev, input int ef, input int erob);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, fu, 0, 0, ev, ef, erob);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst                     = v.rs;
    flush                   = v.fl;
    dispatch_valid          = v.dv;
    dispatch_entry.rob_id   = v.rob;
    dispatch_entry.rd_addr  = v.rob;
    dispatch_entry.pd_addr  = {1'b0, v.rob} + 6'd32;
    dispatch_entry.ps1_addr = v.ps1;
    dispatch_entry.ps2_addr = v.ps2;
    dispatch_entry.funct3   = MD_MUL;
    dispatch_ps1_ready      = v.r1;
    dispatch_ps2_ready      = v.r2;
    cdb.ready               = v.cr;
    cdb.pr_dest             = v.cd;
    cdb.rob_id              = '0;
    cdb.rd_addr             = '0;
    cdb.data                = 32'hDEAD_BEEF;
    fu_ready                = v.fu;
  endtask

  task automatic idleInputs();
    vec_t v;
    v = '{default: '0};
    applyStimulus(v);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatchOne(input int rob, input int ps1, input int ps2,
                             input int r1, input int r2, input int fu);
    vec_t v;
    v = '{default: '0};
    v.dv = 1'b1; v.rob = 5'(rob); v.ps1 = 6'(ps1); v.ps2 = 6'(ps2);
    v.r1 = 1'(r1); v.r2 = 1'(r2); v.fu = 1'(fu);
    applyStimulus(v);
  endtask

  initial begin
    int waited;

    // Vector table: each row's expectations are the outputs seen before its edge
    // Both sources ready, issue next cycle, freed after
    addVec(1, 1, 3, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 1);
    idle(1, 0, 0, 0);
    // ps1=5 unready, broadcast 5 two cycles later, valid exactly one cycle after
    addVec(1, 2, 5, 6, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 2);
    idle(1, 0, 0, 0);
    // Bypass wakeup of ps2=7 in the dispatch cycle
    addVec(1, 3, 8, 7, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 0, 3);
    idle(1, 1, 0, 3);
    idle(1, 0, 0, 0);
    // Fill four, full holds through same-cycle issue, in-order drain with reuse
    addVec(1, 4, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 5, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4);
    addVec(1, 6, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4);
    addVec(1, 7, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4);
    idle(0, 1, 1, 4);
    idle(1, 1, 1, 4);
    addVec(1, 8, 1, 2, 1, 1, 0, 0, 1, 0, 0, 1, 0, 5);
    idle(1, 1, 0, 6);
    idle(1, 1, 0, 7);
    idle(1, 1, 0, 8);
    idle(1, 0, 0, 0);
    // Older unready A, younger ready B: B first, then woken A; pr_dest 0 harmless
    addVec(1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 10);
    addVec(0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
    idle(1, 1, 0, 9);
    idle(1, 0, 0, 0);
    // Flush with three valid plus dispatch, then the same with rst
    addVec(1, 11, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 12, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 11);
    addVec(1, 13, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 11);
    addVec(1, 14, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1, 0, 0, 0);
    addVec(1, 15, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 16, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 15);
    addVec(1, 17, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 15);
    addVec(1, 18, 1, 2, 1, 1, 0, 0, 1, 0, 1, 1, 0, 15);
    idle(1, 0, 0, 0);

    // Reset and check the reset state
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset full", int'(full), 0);
    checkOutput("reset valid", int'(rs_entry_valid), 0);
    tick();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("v%0d valid", k), int'(rs_entry_valid), int'(vecs[k].ev));
      checkOutput($sformatf("v%0d full", k), int'(full), int'(vecs[k].ef));
      if (vecs[k].ev) begin
        checkOutput($sformatf("v%0d rob_id", k), int'(rs_entry_dout.rob_id), int'(vecs[k].erob));
        checkOutput($sformatf("v%0d pd_addr", k), int'(rs_entry_dout.pd_addr),
                    int'(vecs[k].erob) + 32);
      end
      tick();
    end

    // Wakeup latency with a bounded wait: ps2=21 broadcast after an idle cycle
    dispatchOne(20, 0, 21, 0, 0, 0);
    #1;
    checkOutput("wake disp valid", int'(rs_entry_valid), 0);
    tick();
    idleInputs();
    tick();
    cdb.ready = 1'b1;
    cdb.pr_dest = 6'd21;
    #1;
    checkOutput("wake same cycle", int'(rs_entry_valid), 0);
    tick();
    idleInputs();
    #1;
    waited = 0;
    while (rs_entry_valid !== 1'b1 && waited < 8) begin
      tick();
      #1;
      waited++;
    end
    if (waited >= 8) $display("[TB] FAIL wake timeout: got no valid, expected valid within 8 cycles");
    checkOutput("wake latency", waited, 0);
    checkOutput("wake rob_id", int'(rs_entry_dout.rob_id), 20);
    fu_ready = 1'b1;
    tick();
    #1;
    checkOutput("wake drained", int'(rs_entry_valid), 0);
    tick();

    // Reset mid-operation with dispatch, wakeup and fu_ready all active
    dispatchOne(21, 1, 2, 1, 1, 0);
    tick();
    dispatchOne(22, 40, 2, 0, 1, 0);
    tick();
    dispatchOne(23, 1, 2, 1, 1, 1);
    cdb.ready = 1'b1;
    cdb.pr_dest = 6'd40;
    rst = 1'b1;
    tick();
    idleInputs();
    #1;
    checkOutput("rst mid full", int'(full), 0);
    checkOutput("rst mid valid", int'(rs_entry_valid), 0);
    dispatchOne(24, 1, 2, 1, 1, 0);
    tick();
    idleInputs();
    #1;
    checkOutput("post rst rob_id", int'(rs_entry_dout.rob_id), 24);
    fu_ready = 1'b1;
    tick();

    // Flush must override a same-cycle wakeup; later broadcast finds nothing
    dispatchOne(25, 30, 2, 0, 1, 1);
    tick();
    idleInputs();
    flush = 1'b1;
    cdb.ready = 1'b1;
    cdb.pr_dest = 6'd30;
    fu_ready = 1'b1;
    tick();
    idleInputs();
    cdb.ready = 1'b1;
    cdb.pr_dest = 6'd30;
    fu_ready = 1'b1;
    #1;
    checkOutput("flush wake valid", int'(rs_entry_valid), 0);
    tick();
    idleInputs();
    #1;
    checkOutput("flush late valid", int'(rs_entry_valid), 0);
    checkOutput("flush late full", int'(full), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
